// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: MDU operation
// encodings and small decode helpers used by the sequencer.
package mdu_seq_pkg;

    typedef enum logic [2:0] {
        MDU_NOP   = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    function automatic logic is_muldiv(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_signed_op(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic is_div_op(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// EX-stage <-> MDU connection: issue signals in, status and HI/LO out.
interface mdu_seq_if
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    mdu_op_e          mdu_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, mdu_op, op_a, op_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, mdu_op, op_a, op_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: right-shift add for multiply,
// left-shift restoring subtract for divide, over a {acc, lo} register pair.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        // Multiply: carry of the add is kept and shifted back into acc
        sum      = {1'b0, acc} + (lo[0] ? {1'b0, operand} : '0);
        // Divide: partial remainder stays below the divisor, so the
        // truncated subtract is exact whenever there is no borrow
        shifted  = {acc, lo[WIDTH-1]};
        borrow   = shifted < {1'b0, operand};
        rem_sub  = shifted[WIDTH-1:0] - operand;
        acc_next = sum[WIDTH:1];
        lo_next  = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            if (!borrow) begin
                acc_next = rem_sub;
                lo_next  = {lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[WIDTH-1:0];
                lo_next  = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO: 32 iterations on
// magnitudes followed by one sign-fixup cycle; MTHI/MTLO write directly.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rstn,
    mdu_seq_if.slave m
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             div_reg;
    logic             neg_res_reg;
    logic             neg_rem_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;

    logic             accept;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] step_acc, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign accept = (state_reg == S_IDLE) && m.start && !m.flush;
    assign sign_a = is_signed_op(m.mdu_op) && m.op_a[WIDTH-1];
    assign sign_b = is_signed_op(m.mdu_op) && m.op_b[WIDTH-1];
    assign abs_a  = sign_a ? -m.op_a : m.op_a;
    assign abs_b  = sign_b ? -m.op_b : m.op_b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (div_reg),
        .acc      (acc_reg),
        .lo       (a_reg),
        .operand  (b_reg),
        .acc_next (step_acc),
        .lo_next  (step_lo)
    );

    // Divide by zero leaves quotient all ones and remainder |a|; with the
    // quotient-negate flag cleared, remainder fixup restores op_a exactly.
    assign prod     = {acc_reg, a_reg};
    assign prod_fix = neg_res_reg ? -prod : prod;
    assign quo_fix  = neg_res_reg ? -a_reg : a_reg;
    assign rem_fix  = neg_rem_reg ? -acc_reg : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept && is_muldiv(m.mdu_op)) state_next = S_CALC;
            S_CALC: begin
                if (m.flush)                               state_next = S_IDLE;
                else if (cnt_reg == CNT_W'(WIDTH - 1))     state_next = S_FIX;
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            div_reg     <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            b_reg       <= '0;
            a_reg       <= '0;
            acc_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (is_muldiv(m.mdu_op)) begin
                            a_reg       <= abs_a;
                            b_reg       <= abs_b;
                            acc_reg     <= '0;
                            cnt_reg     <= '0;
                            div_reg     <= is_div_op(m.mdu_op);
                            neg_res_reg <= (sign_a ^ sign_b) &&
                                           !(is_div_op(m.mdu_op) && (m.op_b == '0));
                            neg_rem_reg <= is_div_op(m.mdu_op) && sign_a;
                        end else if (m.mdu_op == MDU_MTHI) begin
                            hi_reg <= m.op_a;
                        end else if (m.mdu_op == MDU_MTLO) begin
                            lo_reg <= m.op_a;
                        end
                    end
                end
                S_CALC: begin
                    if (!m.flush) begin
                        acc_reg <= step_acc;
                        a_reg   <= step_lo;
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_FIX: begin
                    if (!m.flush) begin
                        done_reg <= 1'b1;
                        if (div_reg) begin
                            hi_reg <= rem_fix;
                            lo_reg <= quo_fix;
                        end else begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m.busy = (state_reg != S_IDLE);
    assign m.done = done_reg;
    assign m.hi   = hi_reg;
    assign m.lo   = lo_reg;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: scoreboard of expected HI/LO per MULT/DIV,
// latency/busy/done timing, MTHI/MTLO, flush and asynchronous reset.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) sif ();

    mdu_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .m    (sif)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          fail_cnt  = 0;
    logic [31:0] model_hi  = '0;
    logic [31:0] model_lo  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The hazard unit must never issue while busy
    always @(posedge clk) begin
        if (rstn === 1'b1 && sif.busy === 1'b1) begin
            assert (sif.start !== 1'b1) else begin
                total_cnt++;
                fail_cnt++;
                $error("FAIL start_while_busy: observed=1 expected=0");
            end
        end
    end

    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sif.start  = 1'b1;
        sif.mdu_op = op;
        sif.op_a   = a;
        sif.op_b   = b;
        @(posedge clk);
        #1;
        sif.start  = 1'b0;
        sif.mdu_op = MDU_NOP;
    endtask

    task automatic run_md(input string tag, input mdu_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int   busy_cycles;
        int   early_done;
        exp_t e;
        sb_q.push_back('{hi: ehi, lo: elo});
        issue(op, a, b);
        busy_cycles = 0;
        early_done  = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (sif.busy === 1'b1) busy_cycles++;
            if (sif.done !== 1'b0) early_done++;
            if (k == 17) begin
                chk({tag, "_hold_hi"}, sif.hi, model_hi);
                chk({tag, "_hold_lo"}, sif.lo, model_lo);
            end
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        chk({tag, "_early_done"}, 32'(early_done), 32'd0);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, sif.done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, sif.busy}, 32'd0);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, sif.hi, e.hi);
            chk({tag, "_lo"}, sif.lo, e.lo);
            model_hi = e.hi;
            model_lo = e.lo;
        end
        $display("txn %s a=%h b=%h -> hi=%h lo=%h", tag, a, b, sif.hi, sif.lo);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, sif.done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        sif.start  = 1'b0;
        sif.flush  = 1'b0;
        sif.mdu_op = MDU_NOP;
        sif.op_a   = '0;
        sif.op_b   = '0;
        rstn       = 1'b1;
        #2 rstn    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, sif.busy}, 32'd0);
        chk("rst_done", {31'd0, sif.done}, 32'd0);
        chk("rst_hi", sif.hi, 32'd0);
        chk("rst_lo", sif.lo, 32'd0);
        rstn = 1'b1;

        // MTHI then MTLO on consecutive cycles
        @(negedge clk);
        sif.start  = 1'b1;
        sif.mdu_op = MDU_MTHI;
        sif.op_a   = 32'hAAAA_0000;
        @(posedge clk);
        #1;
        sif.mdu_op = MDU_MTLO;
        sif.op_a   = 32'h0000_5555;
        chk("mthi_hi", sif.hi, 32'hAAAA_0000);
        chk("mthi_lo", sif.lo, 32'd0);
        chk("mthi_busy", {31'd0, sif.busy}, 32'd0);
        @(posedge clk);
        #1;
        sif.start  = 1'b0;
        sif.mdu_op = MDU_NOP;
        chk("mtlo_lo", sif.lo, 32'h0000_5555);
        chk("mtlo_hi", sif.hi, 32'hAAAA_0000);
        chk("mtlo_busy", {31'd0, sif.busy}, 32'd0);
        chk("mtlo_done", {31'd0, sif.done}, 32'd0);
        model_hi = 32'hAAAA_0000;
        model_lo = 32'h0000_5555;
        $display("txn mthi/mtlo -> hi=%h lo=%h", sif.hi, sif.lo);

        // start together with flush in IDLE: nothing accepted
        @(negedge clk);
        sif.start  = 1'b1;
        sif.flush  = 1'b1;
        sif.mdu_op = MDU_MULT;
        sif.op_a   = 32'd3;
        sif.op_b   = 32'd5;
        @(posedge clk);
        #1;
        sif.mdu_op = MDU_MTHI;
        sif.op_a   = 32'h1111_1111;
        chk("flush_idle_busy", {31'd0, sif.busy}, 32'd0);
        @(posedge clk);
        #1;
        sif.start  = 1'b0;
        sif.flush  = 1'b0;
        sif.mdu_op = MDU_NOP;
        chk("flush_idle_hi", sif.hi, model_hi);
        chk("flush_idle_busy2", {31'd0, sif.busy}, 32'd0);
        $display("txn start+flush idle -> busy=%b hi=%h", sif.busy, sif.hi);

        run_md("mult",    MDU_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md("multu",   MDU_MULTU, 32'hFFFF_FFFD, 32'd5,        32'h0000_0004, 32'hFFFF_FFF1);
        run_md("div_pn",  MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("div_np",  MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu",    MDU_DIVU,  32'd100,       32'd7,        32'd2,         32'd14);
        run_md("divu_z",  MDU_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
        run_md("div_ovf", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
        run_md("div_z",   MDU_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // flush around iteration 20 of DIVU
        issue(MDU_DIVU, 32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        sif.flush = 1'b1;
        @(posedge clk);
        #1;
        sif.flush = 1'b0;
        @(negedge clk);
        chk("flush_calc_busy", {31'd0, sif.busy}, 32'd0);
        chk("flush_calc_hi", sif.hi, model_hi);
        chk("flush_calc_lo", sif.lo, model_lo);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (sif.done !== 1'b0) done_seen++;
        end
        chk("flush_calc_nodone", 32'(done_seen), 32'd0);
        $display("txn divu flushed -> hi=%h lo=%h", sif.hi, sif.lo);

        // asynchronous reset mid-CALC
        issue(MDU_MULT, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("rst_mid_hi", sif.hi, 32'd0);
        chk("rst_mid_lo", sif.lo, 32'd0);
        chk("rst_mid_busy", {31'd0, sif.busy}, 32'd0);
        chk("rst_mid_done", {31'd0, sif.done}, 32'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rstn = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (sif.done !== 1'b0) done_seen++;
        end
        chk("rst_mid_nodone", 32'(done_seen), 32'd0);
        $display("txn mult reset mid-calc -> hi=%h lo=%h", sif.hi, sif.lo);

        run_md("mult_after_rst", MDU_MULT, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
